// File: rtl/music_box_pkg.sv
// Shared envelope state encoding and default envelope shape for the music box key bank.
package music_box_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam int DEF_ATTACK_STEP   = 32;
    localparam int DEF_DECAY_STEP    = 3;
    localparam int DEF_SUSTAIN_LEVEL = 200;
    localparam int DEF_RELEASE_STEP  = 2;

    localparam logic [4:0] PLAY_STATE_A = 5'd0;
    localparam logic [4:0] PLAY_STATE_B = 5'd4;

    function automatic logic play_allowed(input logic [4:0] st);
        return (st == PLAY_STATE_A) || (st == PLAY_STATE_B);
    endfunction

endpackage

// File: rtl/envelope_channel.sv
// One ADSR envelope channel: edge-detects its key on tick cycles and steps a saturating amplitude.
//
// state       | meaning
// ENV_IDLE    | silent, amplitude 0
// ENV_ATTACK  | rising by ATTACK_STEP toward full scale
// ENV_DECAY   | falling by DECAY_STEP toward SUSTAIN_LEVEL
// ENV_SUSTAIN | holding SUSTAIN_LEVEL while key held
// ENV_RELEASE | falling by RELEASE_STEP toward 0
module envelope_channel
    import music_box_pkg::*;
#(
    parameter int AMP_WIDTH     = 8,
    parameter int ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter int DECAY_STEP    = DEF_DECAY_STEP,
    parameter int SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter int RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  logic                 i_clk,
    input  logic                 i_clear,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_key,
    output logic [AMP_WIDTH-1:0] o_amp,
    output logic                 o_active
);

    localparam int AW1 = AMP_WIDTH + 1;
    localparam logic [AW1-1:0] AMP_MAX = {1'b0, {AMP_WIDTH{1'b1}}};
    localparam logic [AW1-1:0] SUS_LVL = AW1'(SUSTAIN_LEVEL);

    env_state_t             r_state;
    logic [AMP_WIDTH-1:0]   r_amp;
    logic                   r_prev;
    logic                   r_armed;

    env_state_t             w_eff_state;
    logic                   w_press;
    logic                   w_release;
    logic [AW1-1:0]         w_amp_ext;
    logic [AW1-1:0]         w_att;
    logic [AW1-1:0]         w_dec;
    logic [AW1-1:0]         w_rel;

    assign w_amp_ext = {1'b0, r_amp};
    assign w_att     = w_amp_ext + AW1'(ATTACK_STEP);
    assign w_dec     = w_amp_ext - AW1'(DECAY_STEP);
    assign w_rel     = w_amp_ext - AW1'(RELEASE_STEP);

    // A key held down through reset stays disarmed until it has been seen released.
    assign w_press   = r_armed & r_prev & ~i_key;
    assign w_release = ~r_prev & i_key;

    always_comb begin
        w_eff_state = r_state;
        if (w_press) begin
            w_eff_state = ENV_ATTACK;
        end else if (w_release && (r_state == ENV_ATTACK || r_state == ENV_DECAY ||
                                   r_state == ENV_SUSTAIN)) begin
            w_eff_state = ENV_RELEASE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= ENV_IDLE;
            r_amp   <= '0;
            r_prev  <= 1'b1;
            r_armed <= i_reset ? i_key : 1'b1;
        end else if (i_tick) begin
            r_prev  <= i_key;
            r_armed <= r_armed | i_key;
            r_state <= w_eff_state;
            case (w_eff_state)
                ENV_ATTACK: begin
                    if (w_att >= AMP_MAX) begin
                        r_amp   <= AMP_MAX[AMP_WIDTH-1:0];
                        r_state <= ENV_DECAY;
                    end else begin
                        r_amp   <= w_att[AMP_WIDTH-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (w_dec[AW1-1] || (w_dec <= SUS_LVL)) begin
                        r_amp   <= SUS_LVL[AMP_WIDTH-1:0];
                        r_state <= ENV_SUSTAIN;
                    end else begin
                        r_amp   <= w_dec[AMP_WIDTH-1:0];
                    end
                end
                ENV_RELEASE: begin
                    if (w_rel[AW1-1] || (w_rel == '0)) begin
                        r_amp   <= '0;
                        r_state <= ENV_IDLE;
                    end else begin
                        r_amp   <= w_rel[AMP_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_amp    = r_amp;
    assign o_active = (r_state != ENV_IDLE);

endmodule

// File: rtl/music_key_envelope_bank.sv
// Bank of per-key envelope generators sharing a 1 kHz tick, with play-state gating and an amplitude summer.
module music_key_envelope_bank
    import music_box_pkg::*;
#(
    parameter int NUM_KEYS      = 6,
    parameter int AMP_WIDTH     = 8,
    parameter int TICK_DIV      = 32,
    parameter int ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter int DECAY_STEP    = DEF_DECAY_STEP,
    parameter int SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter int RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  logic                                          CLK_32Khz,
    input  logic                                          reset,
    input  logic [4:0]                                    currentState,
    input  logic [NUM_KEYS-1:0]                           input_MusicKey,
    output logic [NUM_KEYS*AMP_WIDTH-1:0]                 envelope_Amplitude,
    output logic [NUM_KEYS-1:0]                           envelope_Active,
    output logic [AMP_WIDTH+$clog2(NUM_KEYS+1)-1:0]       envelope_Sum
);

    localparam int SUM_W = AMP_WIDTH + $clog2(NUM_KEYS + 1);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_tick_cnt;
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_sum;
    logic             w_tick;
    logic             w_clear;

    assign w_tick  = (r_tick_cnt == CNT_LAST);
    // Leaving a play state silences every channel on the very next clock, tick or not.
    assign w_clear = reset | ~play_allowed(currentState);

    always_ff @(posedge CLK_32Khz) begin
        if (reset || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        envelope_channel #(
            .AMP_WIDTH     (AMP_WIDTH),
            .ATTACK_STEP   (ATTACK_STEP),
            .DECAY_STEP    (DECAY_STEP),
            .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
            .RELEASE_STEP  (RELEASE_STEP)
        ) u_channel (
            .i_clk    (CLK_32Khz),
            .i_clear  (w_clear),
            .i_reset  (reset),
            .i_tick   (w_tick),
            .i_key    (input_MusicKey[k]),
            .o_amp    (envelope_Amplitude[k*AMP_WIDTH +: AMP_WIDTH]),
            .o_active (envelope_Active[k])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_sum = w_sum + SUM_W'(envelope_Amplitude[k*AMP_WIDTH +: AMP_WIDTH]);
        end
    end

    always_ff @(posedge CLK_32Khz) begin
        if (reset) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    assign envelope_Sum = r_sum;

endmodule

// File: tb/tb_music_key_envelope_bank.sv
// Directed bench for music_key_envelope_bank with default parameters and hand-computed envelopes.
module tb_music_key_envelope_bank;

    localparam int TICK_DIV = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  currentState;
    logic [5:0]  keys;
    logic [47:0] envelope_Amplitude;
    logic [5:0]  envelope_Active;
    logic [10:0] envelope_Sum;

    int n_total = 0;
    int n_fail  = 0;
    int ph      = 0;

    always #5 clk = ~clk;

    music_key_envelope_bank dut (
        .CLK_32Khz          (clk),
        .reset              (reset),
        .currentState       (currentState),
        .input_MusicKey     (keys),
        .envelope_Amplitude (envelope_Amplitude),
        .envelope_Active    (envelope_Active),
        .envelope_Sum       (envelope_Sum)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] amp_of(input int k);
        return envelope_Amplitude[k*8 +: 8];
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
        ph = (ph + 1) % TICK_DIV;
    endtask

    task automatic step_tick();
        do clk1(); while (ph != 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ph = 0;
    endtask

    initial begin
        int exp_amp;
        int atk_tab[8] = '{32, 64, 96, 128, 160, 192, 224, 255};

        reset        = 1'b1;
        currentState = 5'd0;
        keys         = 6'b111111;
        @(posedge clk);
        do_reset();

        chk("rst_amp",    64'(envelope_Amplitude), 64'd0);
        chk("rst_active", 64'(envelope_Active),    64'd0);
        chk("rst_sum",    64'(envelope_Sum),       64'd0);

        // key0 attack
        keys[0] = 1'b0;
        step_tick();
        chk("atk1", 64'(amp_of(0)), 64'd32);
        clk1();
        chk("atk1_hold", 64'(amp_of(0)), 64'd32);
        chk("atk1_sum",  64'(envelope_Sum), 64'd32);
        for (int t = 2; t <= 8; t++) begin
            step_tick();
            chk($sformatf("atk%0d", t), 64'(amp_of(0)), 64'(atk_tab[t-1]));
        end
        chk("atk_active", 64'(envelope_Active), 64'd1);

        // decay to sustain
        for (int d = 1; d <= 19; d++) begin
            step_tick();
            exp_amp = 255 - 3 * d;
            if (exp_amp < 200) exp_amp = 200;
            chk($sformatf("dec%0d", d), 64'(amp_of(0)), 64'(exp_amp));
        end
        for (int s = 1; s <= 3; s++) begin
            step_tick();
            chk($sformatf("sus%0d", s), 64'(amp_of(0)), 64'd200);
        end

        // release from sustain
        keys[0] = 1'b1;
        for (int r = 1; r <= 100; r++) begin
            step_tick();
            chk($sformatf("rel%0d", r), 64'(amp_of(0)), 64'(200 - 2 * r));
            if (r == 99) chk("rel99_active", 64'(envelope_Active[0]), 64'd1);
        end
        chk("rel_idle_active", 64'(envelope_Active[0]), 64'd0);

        // key2: release mid-attack then retrigger from the decayed level
        keys[2] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            step_tick();
            chk($sformatf("k2_atk%0d", t), 64'(amp_of(2)), 64'(32 * t));
        end
        keys[2] = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            step_tick();
            chk($sformatf("k2_rel%0d", r), 64'(amp_of(2)), 64'(128 - 2 * r));
        end
        keys[2] = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            step_tick();
            exp_amp = 108 + 32 * t;
            if (exp_amp > 255) exp_amp = 255;
            chk($sformatf("k2_retrig%0d", t), 64'(amp_of(2)), 64'(exp_amp));
        end

        // all keys to sustain
        keys = 6'b000000;
        for (int t = 0; t < 30; t++) step_tick();
        for (int k = 0; k < 6; k++) chk($sformatf("all_sus%0d", k), 64'(amp_of(k)), 64'd200);
        chk("all_active", 64'(envelope_Active), 64'h3f);
        clk1();
        chk("all_sum", 64'(envelope_Sum), 64'd1200);

        // leaving play state
        currentState = 5'd2;
        clk1();
        chk("gate_amp",    64'(envelope_Amplitude), 64'd0);
        chk("gate_active", 64'(envelope_Active),    64'd0);
        chk("gate_sum_lag", 64'(envelope_Sum),      64'd1200);
        clk1();
        chk("gate_sum", 64'(envelope_Sum), 64'd0);
        keys = 6'b111111;
        clk1();
        currentState = 5'd4;

        // reset mid-envelope with key held
        keys[1] = 1'b0;
        for (int t = 1; t <= 8; t++) step_tick();
        chk("k1_peak", 64'(amp_of(1)), 64'd255);
        do_reset();
        chk("rst2_amp",    64'(envelope_Amplitude), 64'd0);
        chk("rst2_active", 64'(envelope_Active),    64'd0);
        chk("rst2_sum",    64'(envelope_Sum),       64'd0);
        keys[3] = 1'b0;
        repeat (TICK_DIV - 1) clk1();
        chk("rst2_pre_tick", 64'(amp_of(3)), 64'd0);
        clk1();
        chk("rst2_first_tick", 64'(amp_of(3)), 64'd32);
        chk("k1_held_no_retrig", 64'(amp_of(1)), 64'd0);
        chk("k1_held_inactive",  64'(envelope_Active[1]), 64'd0);
        step_tick();
        step_tick();
        chk("k1_still_silent", 64'(amp_of(1)), 64'd0);
        keys[1] = 1'b1;
        step_tick();
        chk("k1_released", 64'(amp_of(1)), 64'd0);
        keys[1] = 1'b0;
        step_tick();
        chk("k1_repress", 64'(amp_of(1)), 64'd32);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
